// File: rtl/flappy_pkg.sv
// Shared game definitions: state encoding, score width and saturation helpers.
package flappy_pkg;

    localparam int unsigned SCORE_W           = 10;
    localparam int unsigned SCORE_MAX_DEFAULT = 999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    // Next score value, held at smax once reached.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                     input logic [SCORE_W-1:0] smax);
        return (s >= smax) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, level debounce and a one-clk press pulse
// on each accepted rising level.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive samples that differ from it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: button conditioning, game-mode FSM, tick/flap gating
// toward the datapath and current/highest score keeping.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_TICKS      = 100,
    parameter int unsigned SCORE_MAX       = SCORE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               btn_flap,
    input  logic               btn_pause,
    input  logic               tick_in,
    input  logic               collision,
    input  logic               pipe_passed,
    output logic               tick_out,
    output logic               flap_out,
    output logic               world_rst,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] current_score,
    output logic [SCORE_W-1:0] highest_score
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    logic               w_flap_press;
    logic               w_pause_press;
    logic [SCORE_W-1:0] w_cur_inc;

    game_state_e        r_state;
    logic               r_tick_out;
    logic               r_flap_out;
    logic               r_world_rst;
    logic               r_pending;
    logic [SCORE_W-1:0] r_cur;
    logic [SCORE_W-1:0] r_high;
    logic [HOLD_W-1:0]  r_hold;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flap_cond (
        .i_clk   (clk),
        .i_rst   (clr),
        .i_btn   (btn_flap),
        .o_press (w_flap_press)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_cond (
        .i_clk   (clk),
        .i_rst   (clr),
        .i_btn   (btn_pause),
        .o_press (w_pause_press)
    );

    assign w_cur_inc = score_inc(r_cur, SCORE_W'(SCORE_MAX));

    // Game-mode FSM; later assignments in PLAY encode the same-clk event priorities.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_tick_out  <= 1'b0;
            r_flap_out  <= 1'b0;
            r_world_rst <= 1'b0;
            r_pending   <= 1'b0;
            r_cur       <= '0;
            r_high      <= '0;
            r_hold      <= '0;
        end else begin
            r_tick_out  <= 1'b0;
            r_flap_out  <= 1'b0;
            r_world_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_flap_press) begin
                        r_state     <= ST_PLAY;
                        r_world_rst <= 1'b1;
                        r_cur       <= '0;
                        r_pending   <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    r_tick_out <= tick_in;
                    if (tick_in) begin
                        r_flap_out <= r_pending;
                        r_pending  <= 1'b0;
                    end
                    if (pipe_passed) begin
                        r_cur <= w_cur_inc;
                        if (w_cur_inc > r_high) begin
                            r_high <= w_cur_inc;
                        end
                    end
                    if (collision) begin
                        r_state   <= ST_OVER;
                        r_hold    <= '0;
                        r_pending <= 1'b0;
                    end else if (w_pause_press) begin
                        r_state <= ST_PAUSE;
                    end else if (w_flap_press) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_press) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (tick_in && (r_hold != HOLD_W'(HOLD_TICKS))) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                    if (w_flap_press && (r_hold == HOLD_W'(HOLD_TICKS))) begin
                        r_state     <= ST_IDLE;
                        r_world_rst <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tick_out      = r_tick_out;
    assign flap_out      = r_flap_out;
    assign world_rst     = r_world_rst;
    assign game_state    = r_state;
    assign current_score = r_cur;
    assign highest_score = r_high;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: action table for the mode FSM plus hand-written
// sequences for debounce timing, same-clk priorities and asynchronous clear.
module tb_flappy_game_ctrl;
    import flappy_pkg::*;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_flap;
    logic       btn_pause;
    logic       tick_in;
    logic       collision;
    logic       pipe_passed;
    logic       tick_out;
    logic       flap_out;
    logic       world_rst;
    logic [1:0] game_state;
    logic [9:0] current_score;
    logic [9:0] highest_score;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cnt_tick = 0;
    int unsigned cnt_flap = 0;
    int unsigned cnt_wr   = 0;
    int unsigned first_wr;

    typedef enum int {A_TICK, A_FLAP, A_PAUSE, A_PASS, A_COLL} act_e;

    typedef struct {
        act_e        act;
        int unsigned arg;
        int unsigned st;
        int unsigned cur;
        int unsigned hi;
        int unsigned ticks;
        int unsigned flaps;
        int unsigned wrs;
    } vec_t;

    vec_t vecs[26];

    always #5 clk = ~clk;

    flappy_game_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_TICKS      (3),
        .SCORE_MAX       (999)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .btn_flap      (btn_flap),
        .btn_pause     (btn_pause),
        .tick_in       (tick_in),
        .collision     (collision),
        .pipe_passed   (pipe_passed),
        .tick_out      (tick_out),
        .flap_out      (flap_out),
        .world_rst     (world_rst),
        .game_state    (game_state),
        .current_score (current_score),
        .highest_score (highest_score)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (tick_out)  cnt_tick++;
        if (flap_out)  cnt_flap++;
        if (world_rst) cnt_wr++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_cnt();
        cnt_tick = 0;
        cnt_flap = 0;
        cnt_wr   = 0;
    endtask

    task automatic press(input bit f, input bit p);
        btn_flap  = f;
        btn_pause = p;
        steps(10);
        btn_flap  = 1'b0;
        btn_pause = 1'b0;
        steps(10);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            step();
        end
    endtask

    task automatic pass(input int n);
        repeat (n) begin
            pipe_passed = 1'b1;
            step();
        end
        pipe_passed = 1'b0;
        step();
    endtask

    task automatic coll();
        collision = 1'b1;
        step();
        collision = 1'b0;
        step();
    endtask

    // Steps up to 12 clks and records the first clk (1-based) with world_rst high.
    task automatic find_wr();
        first_wr = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (world_rst && first_wr == 0) first_wr = i;
        end
    endtask

    initial begin
        //                act      arg   st  cur  hi  tk fl wr
        vecs[0]  = '{A_TICK,  1,    0,  0,   0,   0, 0, 0};
        vecs[1]  = '{A_PAUSE, 0,    0,  0,   0,   0, 0, 0};
        vecs[2]  = '{A_FLAP,  0,    1,  0,   0,   0, 0, 1};
        vecs[3]  = '{A_TICK,  1,    1,  0,   0,   1, 0, 0};
        vecs[4]  = '{A_FLAP,  0,    1,  0,   0,   0, 0, 0};
        vecs[5]  = '{A_TICK,  1,    1,  0,   0,   1, 1, 0};
        vecs[6]  = '{A_TICK,  1,    1,  0,   0,   1, 0, 0};
        vecs[7]  = '{A_PASS,  1002, 1,  999, 999, 0, 0, 0};
        vecs[8]  = '{A_COLL,  0,    3,  999, 999, 0, 0, 0};
        vecs[9]  = '{A_TICK,  1,    3,  999, 999, 0, 0, 0};
        vecs[10] = '{A_FLAP,  0,    3,  999, 999, 0, 0, 0};
        vecs[11] = '{A_TICK,  4,    3,  999, 999, 0, 0, 0};
        vecs[12] = '{A_FLAP,  0,    0,  999, 999, 0, 0, 1};
        vecs[13] = '{A_FLAP,  0,    1,  0,   999, 0, 0, 1};
        vecs[14] = '{A_PASS,  4,    1,  4,   999, 0, 0, 0};
        vecs[15] = '{A_PAUSE, 0,    2,  4,   999, 0, 0, 0};
        vecs[16] = '{A_FLAP,  0,    2,  4,   999, 0, 0, 0};
        vecs[17] = '{A_PASS,  3,    2,  4,   999, 0, 0, 0};
        vecs[18] = '{A_COLL,  0,    2,  4,   999, 0, 0, 0};
        vecs[19] = '{A_TICK,  1,    2,  4,   999, 0, 0, 0};
        vecs[20] = '{A_PAUSE, 0,    1,  4,   999, 0, 0, 0};
        vecs[21] = '{A_TICK,  1,    1,  4,   999, 1, 0, 0};
        vecs[22] = '{A_FLAP,  0,    1,  4,   999, 0, 0, 0};
        vecs[23] = '{A_PAUSE, 0,    2,  4,   999, 0, 0, 0};
        vecs[24] = '{A_PAUSE, 0,    1,  4,   999, 0, 0, 0};
        vecs[25] = '{A_TICK,  1,    1,  4,   999, 1, 1, 0};

        clr         = 1'b1;
        btn_flap    = 1'b0;
        btn_pause   = 1'b0;
        tick_in     = 1'b1;
        collision   = 1'b0;
        pipe_passed = 1'b0;
        steps(3);
        chk("reset state",     32'(game_state),    0);
        chk("reset tick_out",  32'(tick_out),      0);
        chk("reset flap_out",  32'(flap_out),      0);
        chk("reset world_rst", 32'(world_rst),     0);
        chk("reset cur",       32'(current_score), 0);
        chk("reset high",      32'(highest_score), 0);
        tick_in = 1'b0;
        clr     = 1'b0;
        steps(2);

        for (int i = 0; i < 26; i++) begin
            clear_cnt();
            case (vecs[i].act)
                A_TICK:  tick(int'(vecs[i].arg));
                A_FLAP:  press(1'b1, 1'b0);
                A_PAUSE: press(1'b0, 1'b1);
                A_PASS:  pass(int'(vecs[i].arg));
                default: coll();
            endcase
            chk($sformatf("v%0d state", i), 32'(game_state),    vecs[i].st);
            chk($sformatf("v%0d cur", i),   32'(current_score), vecs[i].cur);
            chk($sformatf("v%0d high", i),  32'(highest_score), vecs[i].hi);
            chk($sformatf("v%0d ticks", i), cnt_tick,           vecs[i].ticks);
            chk($sformatf("v%0d flaps", i), cnt_flap,           vecs[i].flaps);
            chk($sformatf("v%0d wrs", i),   cnt_wr,             vecs[i].wrs);
        end

        // Back to IDLE, then a bouncing flap input: only the final clean rise counts.
        coll();
        tick(3);
        press(1'b1, 1'b0);
        chk("over to idle", 32'(game_state), 0);
        clear_cnt();
        for (int k = 0; k < 10; k++) begin
            btn_flap = (k % 2 == 0);
            steps(2);
        end
        btn_flap = 1'b1;
        find_wr();
        chk("bounce wr count", cnt_wr, 1);
        chk("bounce wr clk",   first_wr, 8);
        btn_flap = 1'b0;
        steps(10);
        chk("bounce state", 32'(game_state), 1);

        // Short glitches on either button must not register.
        btn_pause = 1'b1;
        steps(3);
        btn_pause = 1'b0;
        steps(12);
        chk("glitch pause state", 32'(game_state), 1);
        btn_flap = 1'b1;
        steps(3);
        btn_flap = 1'b0;
        steps(12);
        clear_cnt();
        tick(1);
        chk("glitch flap ticks", cnt_tick, 1);
        chk("glitch flap flaps", cnt_flap, 0);

        // Three presses between ticks merge into one flap.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        clear_cnt();
        tick(1);
        chk("merge flaps", cnt_flap, 1);
        clear_cnt();
        tick(1);
        chk("merge next flaps", cnt_flap, 0);

        // Press arriving on the same clk as tick_in waits for the following tick.
        btn_flap = 1'b1;
        steps(7);
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        chk("tick+press tick_out", 32'(tick_out), 1);
        chk("tick+press flap_out", 32'(flap_out), 0);
        btn_flap = 1'b0;
        steps(12);
        clear_cnt();
        tick(1);
        chk("tick+press deferred flap", cnt_flap, 1);

        // Collision, pipe_passed and pause press together at score 7.
        pass(7);
        chk("pre-collision cur", 32'(current_score), 7);
        btn_pause = 1'b1;
        steps(7);
        collision   = 1'b1;
        pipe_passed = 1'b1;
        step();
        collision   = 1'b0;
        pipe_passed = 1'b0;
        btn_pause   = 1'b0;
        steps(12);
        chk("priority state", 32'(game_state),    3);
        chk("priority cur",   32'(current_score), 8);
        chk("priority high",  32'(highest_score), 999);
        clear_cnt();
        tick(2);
        chk("over ticks", cnt_tick, 0);
        chk("over state", 32'(game_state), 3);

        // Simultaneous pause and flap in PLAY: pause wins, flap is dropped.
        tick(3);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("restart state", 32'(game_state), 1);
        press(1'b1, 1'b1);
        chk("pause+flap state", 32'(game_state), 2);
        press(1'b0, 1'b1);
        clear_cnt();
        tick(1);
        chk("pause+flap flaps", cnt_flap, 0);
        chk("resume state", 32'(game_state), 1);

        // Asynchronous clear in the middle of a game.
        pass(5);
        chk("pre-clear cur", 32'(current_score), 5);
        tick_in = 1'b1;
        step();
        chk("pre-clear tick_out", 32'(tick_out), 1);
        clr = 1'b1;
        #2;
        chk("clr state",    32'(game_state),    0);
        chk("clr tick_out", 32'(tick_out),      0);
        chk("clr cur",      32'(current_score), 0);
        chk("clr high",     32'(highest_score), 0);
        clear_cnt();
        btn_flap = 1'b1;
        steps(10);
        chk("clr held tick", cnt_tick, 0);
        chk("clr held wr",   cnt_wr,   0);
        chk("clr held state", 32'(game_state), 0);
        tick_in  = 1'b0;
        btn_flap = 1'b0;
        steps(2);
        clr = 1'b0;
        steps(2);
        clear_cnt();
        btn_flap = 1'b1;
        find_wr();
        chk("start wr clk", first_wr, 8);
        chk("start wr count", cnt_wr, 1);
        chk("start state", 32'(game_state), 1);
        btn_flap = 1'b0;
        steps(10);
        clear_cnt();
        tick(1);
        chk("first tick ticks", cnt_tick, 1);
        chk("first tick flaps", cnt_flap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
